// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared types and constants for the RAM-to-FFT read controller.
// Optional behaviour in the top level is selected with RAM_RD_CTRL_REPEAT_EN.
package ram_rd_pkg;

   // Controller states; also driven out on the debug state port.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // RAM read latency in cycles (ram_dout valid one cycle after rd_en).
   localparam int RD_LAT     = 1;

   // Output buffer depth; the read credit logic never lets more than this
   // many samples be buffered or in flight at once.
   localparam int SKID_DEPTH = 2;

   // Channel tag width: at least one bit even for a single channel.
   function automatic int ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// fft_skid_buf: 2-entry show-ahead FIFO of {data, last, ch} that absorbs FFT
// backpressure. The head entry is always presented on the out_* ports, so it
// stays stable until it is popped. The caller guarantees no push when full
// and no pop when empty.
module fft_skid_buf
   import ram_rd_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CH_W   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
   input  logic [CH_W-1:0]   push_ch,
   input  logic              pop,
   output logic [1:0]        fill,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [CH_W-1:0]   out_ch
);

   // Two entries, so single-bit read/write pointers toggle on each use.
   logic [DATA_W-1:0] data_mem [SKID_DEPTH];
   logic              last_mem [SKID_DEPTH];
   logic [CH_W-1:0]   ch_mem   [SKID_DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;

   // Storage and pointer update; entries are cleared on reset so the
   // show-ahead outputs come up as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            data_mem[i] <= '0;
            last_mem[i] <= 1'b0;
            ch_mem[i]   <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
            ch_mem[wr_ptr]   <= push_ch;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Occupancy count; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign fill      = count;
   assign out_valid = (count != 2'd0);
   assign out_data  = data_mem[rd_ptr];
   assign out_last  = last_mem[rd_ptr];
   assign out_ch    = ch_mem[rd_ptr];

endmodule

// File: rtl/ram_rd_fft_ctrl.sv
// ram_rd_fft_ctrl: reads NCH channel frames of DEPTH samples from the capture
// RAM (channel-major) and streams them to the FFT with per-frame last and
// channel tags. Define RAM_RD_CTRL_REPEAT_EN to let a held-high start chain
// passes back-to-back without returning to IDLE.
//
// Stream handshake (fft_valid/fft_ready): a beat transfers on every rising
// clock edge where both are high. Once fft_valid is high it stays high, and
// fft_data/fft_last/fft_ch stay unchanged, until that beat transfers.
// fft_valid never depends combinationally on fft_ready.
module ram_rd_fft_ctrl
   import ram_rd_pkg::*;
#(
   parameter int DEPTH  = 4096,
   parameter int NCH    = 1,
   parameter int DATA_W = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CH_W   = ch_width(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [CH_W-1:0]   rd_ch,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              fft_valid,
   input  logic              fft_ready,
   output logic [DATA_W-1:0] fft_data,
   output logic              fft_last,
   output logic [CH_W-1:0]   fft_ch,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);

   rd_state_t         state_q;
   rd_state_t         state_d;
   logic              start_d;
   logic              start_rise;
   logic              inflight_q;
   logic              tag_last_q;
   logic [CH_W-1:0]   tag_ch_q;
   logic              done_q;
   logic              pop;
   logic [1:0]        fill;
   logic [2:0]        occ;
   logic              issue_last;
   logic              final_pop;

   assign start_rise = start & ~start_d;
   assign pop        = fft_valid & fft_ready;

   // Projected buffer occupancy one cycle ahead: what is stored, plus the
   // read already in flight from the RAM, minus the beat leaving now. A new
   // read is only issued while this leaves room for its data.
   assign occ   = {1'b0, fill} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en = (state_q == RUN) && (occ < 3'(SKID_DEPTH));

   assign issue_last = rd_en && (rd_addr == ADDR_LAST) && (rd_ch == CH_LAST);
   assign final_pop  = pop && fft_last && (fft_ch == CH_LAST);

   // Start edge detector register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_d <= 1'b0;
      end else begin
         start_d <= start;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: IDLE waits for a start edge, RUN issues reads until
   // the last address of the last channel, DRAIN waits for that sample to
   // leave the buffer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (issue_last) begin
`ifdef RAM_RD_CTRL_REPEAT_EN
               // Start still high: chain straight into the next pass.
               if (!start) begin
                  state_d = DRAIN;
               end
`else
               state_d = DRAIN;
`endif
            end
         end
         DRAIN: begin
            if (final_pop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address/channel counters: cleared on a new pass, advanced per issued
   // read, wrapping the address into the next channel and the channel back
   // to zero after the last one (which also seeds a chained pass).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr <= '0;
         rd_ch   <= '0;
      end else if ((state_q == IDLE) && start_rise) begin
         rd_addr <= '0;
         rd_ch   <= '0;
      end else if (rd_en) begin
         if (rd_addr == ADDR_LAST) begin
            rd_addr <= '0;
            rd_ch   <= (rd_ch == CH_LAST) ? '0 : rd_ch + CH_W'(1);
         end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
         end
      end
   end

   // Read pipeline: remembers that a read is in flight and the tags of that
   // read so they can be attached to ram_dout when it arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         tag_last_q <= 1'b0;
         tag_ch_q   <= '0;
      end else begin
         inflight_q <= rd_en;
         tag_last_q <= (rd_addr == ADDR_LAST);
         tag_ch_q   <= rd_ch;
      end
   end

   // Pass completion pulse, one cycle after the final beat is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= final_pop;
      end
   end

   fft_skid_buf #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (ram_dout),
      .push_last (tag_last_q),
      .push_ch   (tag_ch_q),
      .pop       (pop),
      .fill      (fill),
      .out_valid (fft_valid),
      .out_data  (fft_data),
      .out_last  (fft_last),
      .out_ch    (fft_ch)
   );

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule
